// File: rtl/mprj_checkpoint_monitor_if.sv
// Configuration, stimulus and status bundle of the checkpoint monitor.
// master drives configuration and the watched field; slave is the monitor itself.
interface mprj_checkpoint_monitor_if #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT_W = 24
);
  logic                       cfg_we;
  logic [$clog2(DEPTH)-1:0]   cfg_addr;
  logic [WIDTH-1:0]           cfg_data;
  logic [$clog2(DEPTH+1)-1:0] cfg_len;
  logic                       cfg_strict;
  logic [TIMEOUT_W-1:0]       step_timeout;
  logic                       start;
  logic [WIDTH-1:0]           watch;
  logic                       busy;
  logic                       pass;
  logic                       fail;
  logic                       timeout;
  logic [$clog2(DEPTH+1)-1:0] step_idx;
  logic [WIDTH-1:0]           last_value;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_len, cfg_strict, step_timeout, start, watch,
    input  busy, pass, fail, timeout, step_idx, last_value
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_len, cfg_strict, step_timeout, start, watch,
    output busy, pass, fail, timeout, step_idx, last_value
  );
endinterface

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint sequencer: waits for a programmed series of stable status values,
// each within a per-step cycle budget, and reports pass / fail / timeout.
module mprj_checkpoint_monitor #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 8,
  parameter int TIMEOUT_W     = 24,
  parameter int STABLE_CYCLES = 2
) (
  input logic                      wb_clk_i,
  input logic                      wb_rst_i,
  mprj_checkpoint_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] SAT_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] OBS_CNT = (STABLE_CYCLES > 1) ? SW'(STABLE_CYCLES - 2) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     expected [DEPTH];
  logic [WIDTH-1:0]     watch_q, last_value;
  logic [SW-1:0]        stab_cnt;
  logic [TIMEOUT_W-1:0] timer, limit_q;
  logic [LW-1:0]        step_idx, len_q, len_in;
  logic                 strict_q, timeout_flag;
  logic                 same, observed, hit, hit_prev, strict_bad, expire, to_timeout, arm;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SAT_MAX) ? v : v + SW'(1);
  endfunction

  always_comb begin
    same       = (bus.watch == watch_q);
    // The edge on which the counter would reach STABLE_CYCLES-1 is the observation edge.
    observed   = (STABLE_CYCLES == 1) ? !same : (same && (stab_cnt == OBS_CNT));
    hit        = observed && (bus.watch == expected[AW'(step_idx)]);
    hit_prev   = (step_idx != '0) && (bus.watch == expected[AW'(step_idx - LW'(1))]);
    strict_bad = strict_q && observed && !hit && !hit_prev;
    expire     = (limit_q != '0) && (timer == limit_q - TIMEOUT_W'(1));
    to_timeout = (state == S_WAIT) && !hit && !strict_bad && expire;
    arm        = bus.start && (state != S_WAIT);
    len_in     = (bus.cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.cfg_len;
    state_nxt  = state;
    case (state)
      S_WAIT: begin
        if (hit) begin
          if (step_idx + LW'(1) == len_q) state_nxt = S_PASS;
        end else if (strict_bad || expire) begin
          state_nxt = S_FAIL;
        end
      end
      default: begin
        if (arm) state_nxt = (len_in == '0) ? S_PASS : S_WAIT;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge wb_clk_i) begin
    watch_q <= bus.watch;
    if (wb_rst_i) begin
      stab_cnt     <= '0;
      last_value   <= '0;
      timer        <= '0;
      step_idx     <= '0;
      timeout_flag <= 1'b0;
      len_q        <= '0;
      strict_q     <= 1'b0;
      limit_q      <= '0;
    end else begin
      stab_cnt <= same ? sat_inc(stab_cnt) : '0;
      if (observed) last_value <= bus.watch;
      if (state == S_WAIT) begin
        if (hit) begin
          step_idx <= step_idx + LW'(1);
          timer    <= '0;
        end else begin
          timer <= timer + TIMEOUT_W'(1);
        end
        if (to_timeout) timeout_flag <= 1'b1;
      end else if (arm) begin
        len_q        <= len_in;
        strict_q     <= bus.cfg_strict;
        limit_q      <= bus.step_timeout;
        step_idx     <= '0;
        timer        <= '0;
        timeout_flag <= 1'b0;
      end
    end
  end

  // Table is left out of reset so firmware need not reprogram it after an abort.
  always_ff @(posedge wb_clk_i) begin
    if (bus.cfg_we && (state != S_WAIT)) expected[bus.cfg_addr] <= bus.cfg_data;
  end

  assign bus.busy       = (state == S_WAIT);
  assign bus.pass       = (state == S_PASS);
  assign bus.fail       = (state == S_FAIL);
  assign bus.timeout    = timeout_flag;
  assign bus.step_idx   = step_idx;
  assign bus.last_value = last_value;
endmodule

// File: doc/mprj_checkpoint_monitor.md
Name: mprj_checkpoint_monitor

Overview:
- Synthesizable, parametrised checkpoint sequencer for the user project area.
- Watches a WIDTH-bit status field, typically mprj_io[31:16] driven by firmware.
- Checks that a programmed sequence of up to DEPTH signature values (e.g. 16'hAB40, 16'hAB41, 16'hAB51) appears in order, each within a per-step cycle budget.
- Reports pass, fail or timeout on-chip, so the LA/GPIO bring-up checks run in silicon as well as in simulation.

Parameters:
- WIDTH, 16, width of the watched status field and of each expected signature.
- DEPTH, 8, maximum number of checkpoints in a sequence.
- TIMEOUT_W, 24, width of the per-step cycle timer and its limit.
- STABLE_CYCLES, 2, consecutive cycles a value must hold before it counts as observed (≥1).

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  reset; synchronous, active-high.
- cfg_we  input  1  write expected[cfg_addr] <= cfg_data.
- cfg_addr  input  $clog2(DEPTH)  signature table index.
- cfg_data  input  WIDTH  signature value.
- cfg_len  input  $clog2(DEPTH+1)  sequence length; sampled on start.
- cfg_strict  input  1  strict mode; sampled on start.
- step_timeout  input  TIMEOUT_W  per-step cycle limit; 0 disables the limit; sampled on start.
- start  input  1  one-cycle pulse that arms the monitor.
- watch  input  WIDTH  observed status field.
- busy  output  1  monitor armed.
- pass  output  1  sticky; sequence completed.
- fail  output  1  sticky; sequence aborted.
- timeout  output  1  sticky; fail cause was the timer (subset of fail).
- step_idx  output  $clog2(DEPTH+1)  number of checkpoints matched so far.
- last_value  output  WIDTH  most recent stable value observed.

Behaviour:
- Reset (synchronous, wb_rst_i=1 at a clock edge):
  - busy, pass, fail, timeout, step_idx, last_value, timer and stability counter all go to 0; state goes to IDLE.
  - The signature table is not reset and keeps its contents.
  - Reset mid-run aborts silently, with no fail flag.
- Signature table: DEPTH x WIDTH registers.
  - Written when cfg_we=1 and state is IDLE, PASS or FAIL.
  - Writes while busy are ignored.
- Stability filter (runs in every state):
  - watch_q <= watch every cycle.
  - stab_cnt <= (watch==watch_q) ? sat_inc(stab_cnt) : 0.
  - A value is observed at the edge where stab_cnt reaches STABLE_CYCLES-1 with watch==watch_q; last_value is updated on that same edge.
  - Observation timing: if watch becomes V just after edge t and holds, V is observed at edge t+STABLE_CYCLES. Each hold of a value produces exactly one observation.
- States:
  - IDLE (busy=0).
    - start=1 latches cfg_len, cfg_strict and step_timeout, clears pass/fail/timeout/step_idx/timer, and goes to WAIT (busy=1 next cycle).
    - If cfg_len==0, go directly to PASS instead.
  - WAIT (busy=1).
    - timer increments every cycle.
    - On observation of expected[step_idx]: step_idx+1 and timer<=0. If this was the last step (step_idx == len-1), go to PASS on the same edge.
    - Strict mode: observing a value that is neither expected[step_idx] nor expected[step_idx-1] (the latter only when step_idx>0) goes to FAIL.
    - Non-strict mode: non-matching observations are ignored.
    - Timer expiry: if step_timeout≠0 and timer == step_timeout-1 with no match on that edge, go to FAIL with timeout=1.
    - A match on the expiry edge wins over the timeout.
    - start while in WAIT is ignored.
  - PASS (pass=1, busy=0) and FAIL (fail=1, busy=0).
    - Flags hold until start or reset.
    - start re-arms as from IDLE on the same edge.
- Outputs are registered; no combinational path from watch to any output.

Test Plan:
- Program AB40/AB41/AB51, len=3, timeout=1000, non-strict; start; drive AB40, AB41, AB51, each held 5 cycles -> step_idx goes 1, 2, 3; pass=1 exactly 2 cycles after AB51 is applied; busy=0; fail=0.
- Same table; drive AB40, then hold AB41 for only 1 cycle (glitch), then 0000 -> no advance past step_idx=1; timer expires at 1000 cycles after the AB40 match -> fail=1, timeout=1.
- Strict mode; drive AB40, then 1234 stable -> fail=1, timeout=0, step_idx=1, last_value=16'h1234. Repeat in non-strict mode -> keeps waiting, busy=1.
- Boundary checks:
  - cfg_len=0 with start -> pass=1 one cycle later.
  - step_timeout=0 with no stimulus for 100k cycles -> busy=1, no fail.
  - Expected value arriving on the expiry edge -> match, no timeout.
- Assert wb_rst_i mid-WAIT at step_idx=2 -> all outputs 0 next edge. Restart without reprogramming -> table is retained and the full sequence passes.
- cfg_we while busy with a new value at index 0 -> table unchanged; the sequence still passes on AB40.
